lsu: RTL and testbench

Load/store unit for the RV32I core, directly downstream of the ALU. It takes the effective address computed by the ALU (rs1 + imm on `alu_out`), the access size and signedness from `funct3`, and the store operand. It runs a single-outstanding request/acknowledge transaction on the data-memory port. For loads, it returns a lane-selected, sign- or zero-extended word to the writeback stage.

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu.sv | 172 +++++++++++++++++
 tb/tb_lsu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I definitions for the load/store unit. Holds the
//                funct3 load/store encodings, the LSU state enum and a helper
//                that classifies illegal load/store encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

    // Load encodings (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings (funct3)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // LSU control states
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_t;

    // Encodings that never name a real access, independent of alignment.
    function automatic logic lsu_illegal_f3(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return funct3[2] || (funct3 == 3'b011);
        else
            return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic for the LSU. Steers store data onto
//                byte lanes with matching byte enables, and selects plus
//                sign/zero-extends the addressed byte/half/word of read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] rdata_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store steering: replicate the operand across lanes, enable only the target bytes.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0000_0000;
        case (st_funct3)
            F3_SB: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            F3_SW: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load formatting: pick the addressed lane, then extend per access type.
    always_comb begin
        rdata_shifted = mem_rdata >> {ld_addr_lo, 3'b000};
        ld_byte       = rdata_shifted[7:0];
        ld_half       = ld_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data       = 32'h0000_0000;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'h00_0000, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'h0000, ld_half};
            F3_LW:   ld_data = mem_rdata;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
//  Module      : lsu
//  Description : RV32I load/store unit. Single-outstanding req/ack access to
//                data memory with a bounded wait and fault reporting.
//                Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
//                half/word accesses fault without issuing a memory request;
//                otherwise the low address bits are truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu
    import rv32i_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        fault,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Counter value seen in the last permitted wait cycle.
    localparam logic [7:0] C_LAST_WAIT = 8'(WAIT_LIMIT - 1);

    lsu_state_t  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        fault_q, fault_d;

    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;
    logic        w_misalign;
    logic        w_reject;

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_addr_lo (addr[1:0]),
        .store_data (store_data),
        .st_be      (w_st_be),
        .st_wdata   (w_st_wdata),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (lane_q),
        .mem_rdata  (mem_rdata),
        .ld_data    (w_ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject = lsu_illegal_f3(is_store, funct3) || w_misalign;

    // Outputs decoded from state; request drops as soon as state resets.
    assign busy      = (state_q != LSU_IDLE);
    assign mem_req   = (state_q == LSU_ACCESS);
    assign done      = (state_q == LSU_DONE);
    assign mem_we    = mem_req && is_store_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign fault     = fault_q;

    // Next-state logic: accept in IDLE, wait for ack or timeout in ACCESS, pulse DONE.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        rd_data_d   = rd_data_q;
        fault_d     = fault_q;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    if (w_reject) begin
                        fault_d   = 1'b1;
                        rd_data_d = 32'h0000_0000;
                        state_d   = LSU_DONE;
                    end else begin
                        is_store_d  = is_store;
                        funct3_d    = funct3;
                        lane_d      = addr[1:0];
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = is_store ? w_st_be : 4'b1111;
                        mem_wdata_d = is_store ? w_st_wdata : 32'h0000_0000;
                        wait_cnt_d  = 8'd0;
                        state_d     = LSU_ACCESS;
                    end
                end
            end
            LSU_ACCESS: begin
                // An ack in the final wait cycle still completes cleanly.
                if (mem_ack) begin
                    rd_data_d = is_store_q ? 32'h0000_0000 : w_ld_data;
                    fault_d   = 1'b0;
                    state_d   = LSU_DONE;
                end else if (wait_cnt_q == C_LAST_WAIT) begin
                    rd_data_d = 32'h0000_0000;
                    fault_d   = 1'b1;
                    state_d   = LSU_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            wait_cnt_q  <= 8'd0;
            rd_data_q   <= 32'h0000_0000;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_data_q   <= rd_data_d;
            fault_q     <= fault_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
//  Module      : tb_lsu
//  Description : Directed self-checking bench for the lsu block (WAIT_LIMIT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    logic [31:0] rd_data;
    logic        done;
    logic        fault;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    int n_total = 0;
    int n_bad   = 0;

    int          got_req;
    int          got_lat;
    logic [31:0] got_rd;
    logic        got_fault;

    lsu #(.WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd_data    (rd_data),
        .done       (done),
        .fault      (fault),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access: ack in the ack_at-th request cycle (0 = never). With pulse set,
    // start is re-asserted with a different access on every busy cycle.
    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdv,
                       input int ack_at, input logic pulse,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
        logic seen;
        int   req;
        int   lat;
        seen       = 1'b0;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        start      = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        req   = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (mem_req) begin
                req++;
                check({tag, ".addr"},  mem_addr,  {a[31:2], 2'b00});
                check({tag, ".we"},    mem_we,    st);
                check({tag, ".be"},    mem_be,    exp_be);
                check({tag, ".wdata"}, mem_wdata, exp_wd);
                if (req == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdv;
                end
            end
            if (pulse) begin
                start      = 1'b1;
                is_store   = 1'b1;
                funct3     = F3_SW;
                addr       = 32'hFFFF_0000;
                store_data = 32'h1111_2222;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            lat++;
        end
        check({tag, ".done_seen"}, seen, 1'b1);
        got_rd    = rd_data;
        got_fault = fault;
        got_req   = req;
        got_lat   = lat;
        if (pulse) start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".done_1cyc"}, done, 1'b0);
        check({tag, ".idle"}, busy, 1'b0);
        if (pulse) begin
            tick();
            check({tag, ".no_2nd_req"}, {30'b0, mem_req, busy}, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst.outs", {27'b0, done, fault, busy, mem_req, mem_we}, 32'h0);
        check("rst.rd", rd_data, 32'h0);
        check("rst.mem", {mem_addr[31:4], mem_addr[3:0] | mem_be}, 32'h0);
        check("rst.wdata", mem_wdata, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // LB / LBU from the top byte lane
        run("lb", 1'b0, F3_LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 1'b0, 4'hF, 32'h0);
        check("lb.rd", got_rd, 32'hFFFF_FF80);
        check("lb.fault", got_fault, 1'b0);
        check("lb.lat", got_lat, 2);
        check("lb.req", got_req, 1);
        run("lbu", 1'b0, F3_LBU, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 1'b0, 4'hF, 32'h0);
        check("lbu.rd", got_rd, 32'h0000_0080);

        // Halves and word
        run("lh", 1'b0, F3_LH, 32'h0000_2002, 32'h0, 32'h80FF_1234, 2, 1'b0, 4'hF, 32'h0);
        check("lh.rd", got_rd, 32'hFFFF_80FF);
        check("lh.lat", got_lat, 3);
        run("lhu", 1'b0, F3_LHU, 32'h0000_2000, 32'h0, 32'h80FF_9234, 1, 1'b0, 4'hF, 32'h0);
        check("lhu.rd", got_rd, 32'h0000_9234);
        run("lw", 1'b0, F3_LW, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 4'hF, 32'h0);
        check("lw.rd", got_rd, 32'hCAFE_F00D);

        // SH held until ack in the 4th request cycle (also the last permitted wait cycle)
        run("sh", 1'b1, F3_SH, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 4, 1'b0, 4'b1100, 32'hBEEF_BEEF);
        check("sh.req", got_req, 4);
        check("sh.lat", got_lat, 5);
        check("sh.fault", got_fault, 1'b0);
        check("sh.rd", got_rd, 32'h0);
        run("sb", 1'b1, F3_SB, 32'h0000_4001, 32'h1234_56A5, 32'h0, 1, 1'b0, 4'b0010, 32'hA5A5_A5A5);
        check("sb.fault", got_fault, 1'b0);
        run("sw", 1'b1, F3_SW, 32'h0000_4000, 32'h1234_56A5, 32'h0, 1, 1'b0, 4'b1111, 32'h1234_56A5);
        check("sw.req", got_req, 1);

        // Misaligned word
        run("lw_mis", 1'b0, F3_LW, 32'h0000_0011, 32'h0, 32'h7654_3210, 1, 1'b0, 4'hF, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis.fault", got_fault, 1'b1);
        check("lw_mis.req", got_req, 0);
        check("lw_mis.lat", got_lat, 1);
        check("lw_mis.rd", got_rd, 32'h0);
`else
        check("lw_mis.fault", got_fault, 1'b0);
        check("lw_mis.req", got_req, 1);
        check("lw_mis.rd", got_rd, 32'h7654_3210);
`endif

        // Timeout: no ack
        run("tmo", 1'b0, F3_LW, 32'h0000_5000, 32'h0, 32'h0, 0, 1'b0, 4'hF, 32'h0);
        check("tmo.req", got_req, 4);
        check("tmo.lat", got_lat, 5);
        check("tmo.fault", got_fault, 1'b1);
        check("tmo.rd", got_rd, 32'h0);

        // Illegal encodings, with start pulsing while busy
        run("ill_ld", 1'b0, 3'b011, 32'h0000_6000, 32'h0, 32'h0, 1, 1'b1, 4'hF, 32'h0);
        check("ill_ld.fault", got_fault, 1'b1);
        check("ill_ld.req", got_req, 0);
        check("ill_ld.lat", got_lat, 1);
        run("ill_st", 1'b1, 3'b100, 32'h0000_6000, 32'h0, 32'h0, 1, 1'b0, 4'hF, 32'h0);
        check("ill_st.fault", got_fault, 1'b1);
        check("ill_st.req", got_req, 0);

        // Long load with start pulsing every busy cycle
        run("busy_lw", 1'b0, F3_LW, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 3, 1'b1, 4'hF, 32'h0);
        check("busy_lw.req", got_req, 3);
        check("busy_lw.rd", got_rd, 32'h0BAD_F00D);
        check("busy_lw.fault", got_fault, 1'b0);

        // Reset in the middle of an access
        is_store = 1'b0;
        funct3   = F3_LW;
        addr     = 32'h0000_7000;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mid.req_before", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid.drop", {29'b0, mem_req, busy, done}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("mid.idle", {29'b0, mem_req, busy, done}, 32'h0);
        run("post_rst", 1'b0, F3_LW, 32'h0000_7004, 32'h0, 32'h1357_9BDF, 1, 1'b0, 4'hF, 32'h0);
        check("post_rst.rd", got_rd, 32'h1357_9BDF);
        check("post_rst.fault", got_fault, 1'b0);
        check("post_rst.lat", got_lat, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
